// File: rtl/dm_port_arbiter_if.sv
// rtl/dm_port_arbiter_if.sv - CPU, DMA and memory port signals of the data-memory arbiter
interface dm_port_arbiter_if;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_byteen;
    logic        cpu_stall;
    logic [31:0] cpu_rdata;
    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [3:0]  dma_len;
    logic [31:0] dma_wdata;
    logic        dma_beat;
    logic [31:0] dma_rdata;
    logic        dma_done;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_data_rdata;
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_dma_cnt;

    modport slave (
        input  cpu_req, cpu_addr, cpu_wdata, cpu_byteen,
        input  dma_req, dma_we, dma_addr, dma_len, dma_wdata,
        input  m_data_rdata,
        output cpu_stall, cpu_rdata, dma_beat, dma_rdata, dma_done,
        output m_data_addr, m_data_wdata, m_data_byteen,
        output perf_stall_cnt, perf_dma_cnt
    );

    modport master (
        output cpu_req, cpu_addr, cpu_wdata, cpu_byteen,
        output dma_req, dma_we, dma_addr, dma_len, dma_wdata,
        output m_data_rdata,
        input  cpu_stall, cpu_rdata, dma_beat, dma_rdata, dma_done,
        input  m_data_addr, m_data_wdata, m_data_byteen,
        input  perf_stall_cnt, perf_dma_cnt
    );
endinterface

// File: rtl/dm_port_arbiter.sv
// rtl/dm_port_arbiter.sv - CPU/DMA data-memory port arbiter with non-preemptible DMA bursts
// Optional perf counters enabled by defining DM_ARB_PERF_CNT_EN.
module dm_port_arbiter #(
    parameter int MAX_BURST    = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    dm_port_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [3:0]    MAX_LEN    = 4'(MAX_BURST);

    typedef enum logic {S_IDLE, S_BURST} state_t;

    state_t        state_q, state_d;
    logic [3:0]    beat_cnt_q, beat_cnt_d;
    logic [31:0]   burst_addr_q, burst_addr_d;
    logic          burst_we_q, burst_we_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          dma_done_q, dma_done_d;

    logic          cpu_own;
    logic          dma_own;
    logic [31:0]   dma_base;
    logic [3:0]    len_min1;
    logic [3:0]    burst_len;
    logic [31:0]   port_addr;
    logic [31:0]   port_wdata;
    logic [3:0]    port_byteen;
    logic          cpu_stall;
    logic          dma_beat;
    logic          unused_addr_bits;

    assign dma_base         = {bus.dma_addr[31:2], 2'b00};
    assign unused_addr_bits = ^bus.dma_addr[1:0];
    assign len_min1         = (bus.dma_len == 4'd0) ? 4'd1 : bus.dma_len;
    assign burst_len        = (len_min1 > MAX_LEN) ? MAX_LEN : len_min1;

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        burst_addr_d = burst_addr_q;
        burst_we_d   = burst_we_q;
        starve_cnt_d = starve_cnt_q;
        dma_done_d   = 1'b0;
        cpu_own      = 1'b0;
        dma_own      = 1'b0;
        port_addr    = 32'h0;
        port_wdata   = 32'h0;
        port_byteen  = 4'h0;
        cpu_stall    = 1'b0;
        dma_beat     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A saturated starvation count lets a waiting DMA jump ahead of the CPU
                cpu_own = bus.cpu_req && !(bus.dma_req && starve_cnt_q == STARVE_MAX);
                dma_own = !cpu_own && bus.dma_req;
                if (cpu_own) begin
                    port_addr   = bus.cpu_addr;
                    port_wdata  = bus.cpu_wdata;
                    port_byteen = bus.cpu_byteen;
                end else if (dma_own) begin
                    port_addr    = dma_base;
                    port_wdata   = bus.dma_wdata;
                    port_byteen  = bus.dma_we ? 4'b1111 : 4'b0000;
                    dma_beat     = 1'b1;
                    burst_addr_d = dma_base + 32'd4;
                    burst_we_d   = bus.dma_we;
                    beat_cnt_d   = burst_len - 4'd1;
                    if (burst_len > 4'd1) begin
                        state_d = S_BURST;
                    end else begin
                        dma_done_d = 1'b1;
                    end
                end
                cpu_stall = bus.cpu_req && !cpu_own;
                if (!bus.dma_req || dma_own) begin
                    starve_cnt_d = '0;
                end else if (starve_cnt_q != STARVE_MAX) begin
                    starve_cnt_d = starve_cnt_q + SW'(1);
                end
            end
            S_BURST: begin
                port_addr    = burst_addr_q;
                port_wdata   = bus.dma_wdata;
                port_byteen  = burst_we_q ? 4'b1111 : 4'b0000;
                dma_beat     = 1'b1;
                cpu_stall    = bus.cpu_req;
                burst_addr_d = burst_addr_q + 32'd4;
                beat_cnt_d   = beat_cnt_q - 4'd1;
                if (beat_cnt_q == 4'd1) begin
                    state_d    = S_IDLE;
                    dma_done_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef DM_ARB_PERF_CNT_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_dma_q, perf_dma_d;

    always_comb begin
        perf_stall_d = perf_stall_q + {31'h0, cpu_stall};
        perf_dma_d   = perf_dma_q + {31'h0, dma_beat};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_stall_q <= 32'h0;
            perf_dma_q   <= 32'h0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_dma_q   <= perf_dma_d;
        end
    end

    assign bus.perf_stall_cnt = perf_stall_q;
    assign bus.perf_dma_cnt   = perf_dma_q;
`else
    assign bus.perf_stall_cnt = 32'h0;
    assign bus.perf_dma_cnt   = 32'h0;
`endif

    // Burst address/direction keep their stale values in reset; they are reloaded on every first beat
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            beat_cnt_q   <= 4'd0;
            starve_cnt_q <= '0;
            dma_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            burst_addr_q <= burst_addr_d;
            burst_we_q   <= burst_we_d;
            starve_cnt_q <= starve_cnt_d;
            dma_done_q   <= dma_done_d;
        end
    end

    assign bus.m_data_addr   = port_addr;
    assign bus.m_data_wdata  = port_wdata;
    assign bus.m_data_byteen = port_byteen;
    assign bus.cpu_stall     = cpu_stall;
    assign bus.cpu_rdata     = bus.m_data_rdata;
    assign bus.dma_beat      = dma_beat;
    assign bus.dma_rdata     = bus.m_data_rdata;
    assign bus.dma_done      = dma_done_q;
endmodule

// File: doc/dm_port_arbiter.md
Name: dm_port_arbiter

Overview:
- Shares the single data-memory port (m_data_addr/m_data_wdata/m_data_byteen/m_data_rdata) between the CPU M stage and a word-burst DMA requester.
- The CPU has priority. A starvation counter forces a DMA grant after STARVE_LIMIT consecutive denied cycles.
- Once started, a DMA burst is non-preemptible. The CPU is stalled for the length of the burst.
- Sits between the mips core's data port and the external memory.

Parameters:
MAX_BURST, 8, maximum beats per DMA burst; longer requests are clamped.
STARVE_LIMIT, 4, consecutive DMA-denied cycles before DMA is forced ahead of the CPU.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (reset==0 resets on rising clk)
cpu_req  in  1  CPU M stage wants the port this cycle (load or store)
cpu_addr  in  32  CPU byte address
cpu_wdata  in  32  CPU store data, already lane-aligned
cpu_byteen  in  4  CPU byte enables; 0 = load
cpu_stall  out  1  CPU request not served this cycle; the core freezes
cpu_rdata  out  32  m_data_rdata passthrough
dma_req  in  1  DMA requests a burst
dma_we  in  1  1 = write burst, 0 = read burst
dma_addr  in  32  burst start address (bits [1:0] ignored)
dma_len  in  4  beat count; 0 treated as 1
dma_wdata  in  32  write data for the current beat
dma_beat  out  1  a DMA beat is on the port this cycle
dma_rdata  out  32  read data for the current beat (m_data_rdata)
dma_done  out  1  one-cycle pulse, the cycle after the last beat
m_data_addr  out  32  memory address
m_data_wdata  out  32  memory write data
m_data_byteen  out  4  memory byte enables
m_data_rdata  in  32  memory read data, combinational on m_data_addr
perf_stall_cnt  out  32  CPU stall cycle count (optional feature)
perf_dma_cnt  out  32  DMA beat count (optional feature)

Behaviour:
- Memory model: read is combinational within the cycle; write commits on the rising clk when m_data_byteen!=0.
- State machine: IDLE and BURST. Registers: state, beat_cnt[3:0], burst_addr[31:0], burst_we, starve_cnt, dma_done.
- Reset (reset==0 at clk edge): state=IDLE, beat_cnt=0, starve_cnt=0, dma_done=0.
  - A reset during BURST aborts the burst; dma_done is not pulsed.
  - Outputs with no owner: m_data_addr=0, m_data_wdata=0, m_data_byteen=0, cpu_stall=0, dma_beat=0.
- IDLE owner selection (combinational):
  - CPU owns if cpu_req && !(dma_req && starve_cnt==STARVE_LIMIT).
  - Else DMA owns if dma_req.
  - Else no owner.
- CPU owned: port driven from the cpu_* inputs; cpu_stall=0.
- DMA first beat (issued in IDLE):
  - Port is driven with address {dma_addr[31:2],2'b00}, byteen = dma_we ? 4'b1111 : 4'b0000, data = dma_wdata; dma_beat=1.
  - L = clamp(max(dma_len,1), MAX_BURST).
  - Latch burst_addr = {dma_addr[31:2],2'b00}+4, burst_we=dma_we, beat_cnt=L-1.
  - Next state is BURST if L>1; otherwise stay IDLE and set dma_done=1 next cycle.
- BURST:
  - DMA owns every cycle: address=burst_addr, byteen per burst_we, data=dma_wdata, dma_beat=1.
  - cpu_stall=cpu_req.
  - Each cycle: burst_addr+=4 (32-bit wrap at 0xFFFFFFFC→0) and beat_cnt-=1.
  - When beat_cnt==1, the beat is the last one; next state is IDLE and dma_done=1 next cycle.
  - dma_req, dma_addr and dma_len are ignored in BURST.
- IDLE stall: cpu_stall = cpu_req && (owner!=CPU).
- starve_cnt:
  - In IDLE, increments (saturating at STARVE_LIMIT) when dma_req && owner==CPU.
  - Cleared when DMA takes a first beat or when dma_req==0.
  - Holds value in BURST.
- dma_done: registered pulse, high exactly one cycle; back-to-back bursts are allowed (a new first beat may coincide with dma_done=1).
- Latency: CPU access 0 extra cycles when uncontended. DMA burst of L beats occupies L consecutive cycles.

Optional Feature:
- Macro: DM_ARB_PERF_CNT_EN.
- Defined:
  - perf_stall_cnt increments every cycle cpu_stall==1.
  - perf_dma_cnt increments every cycle dma_beat==1.
  - Both are 32-bit wrapping counters, cleared by reset.
- Undefined: no counter registers; both ports tied to 32'h0.

Test Plan:
1. CPU alone: cpu_req=1, addr=0x100, byteen=4'b1111, wdata=0xDEADBEEF; no dma_req → m_data_addr=0x100, byteen=1111, cpu_stall=0, same cycle.
2. DMA alone: dma_req=1, we=1, addr=0x203, len=3, wdata 0xA,0xB,0xC → addresses 0x200,0x204,0x208 on 3 consecutive cycles, dma_beat=1 each; dma_done pulses on cycle 4; state returns to IDLE.
3. Contention/starvation (STARVE_LIMIT=4): cpu_req and dma_req held high → CPU served 4 cycles, DMA first beat on cycle 5 with cpu_stall=1; with len=2, CPU stalled 2 cycles, then served again; starve_cnt=0.
4. Clamp/zero length: len=0 → exactly 1 beat then dma_done; len=15 with MAX_BURST=8 → exactly 8 beats.
5. Reset mid-burst: len=8, reset=0 during beat 3 → next cycle m_data_byteen=0, dma_beat=0, no dma_done pulse, state IDLE; reset=1 with cpu_req=1 → CPU served immediately.
6. DM_ARB_PERF_CNT_EN defined, scenario 3 → perf_stall_cnt=2, perf_dma_cnt=2; undefined → both read 0.
